// File: rtl/result_buf.sv
// result_buf: double-buffered (ping-pong) result store.
// Captures NUM parallel words in one cycle into the write bank and streams
// the oldest full bank out serially with a valid/ready handshake.
module result_buf #(
  parameter int DATA_W = 16,
  parameter int NUM    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  save_sop,
  input  logic [NUM*DATA_W-1:0] save_data,
  output logic                  save_ready,
  output logic                  save_ovf,
  input  logic                  rd_sop,
  input  logic                  rd_rdy,
  output logic                  rd_vld,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_eop,
  output logic                  rd_err,
  output logic [1:0]            buf_cnt
);

  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [1:0]        full_reg, full_next;
  logic              wr_sel_reg, wr_sel_next;
  logic              rd_sel_reg, rd_sel_next;
  logic              save_ovf_reg, save_ovf_next;
  logic              rd_err_reg, rd_err_next;

  logic              fin;
  logic              save_acc;
  logic [NUM*DATA_W-1:0] bank0_flat, bank1_flat;

  // Last word of a set accepted this cycle: frees the read bank.
  assign fin = (state_reg == STREAM) && rd_rdy && (idx_reg == LAST_IDX);

  // A bank is free, or the read bank is being freed right now.
  assign save_ready = ~(full_reg[0] & full_reg[1]) | fin;
  assign save_acc   = save_sop & save_ready;

  // Bank storage: one register pair per word, written only by accepted saves.
  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_word
      logic [DATA_W-1:0] w0_reg, w1_reg;

      // Capture word gi into whichever bank is currently the write bank.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w0_reg <= '0;
          w1_reg <= '0;
        end else if (save_acc) begin
          if (wr_sel_reg) w1_reg <= save_data[gi*DATA_W +: DATA_W];
          else            w0_reg <= save_data[gi*DATA_W +: DATA_W];
        end
      end

      assign bank0_flat[gi*DATA_W +: DATA_W] = w0_reg;
      assign bank1_flat[gi*DATA_W +: DATA_W] = w1_reg;
    end
  endgenerate

  // State register for the read FSM, bank bookkeeping and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      full_reg     <= 2'b00;
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      save_ovf_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      full_reg     <= full_next;
      wr_sel_reg   <= wr_sel_next;
      rd_sel_reg   <= rd_sel_next;
      save_ovf_reg <= save_ovf_next;
      rd_err_reg   <= rd_err_next;
    end
  end

  // Next-state logic; a save coinciding with fin on the same bank keeps it full
  // because the set is applied after the clear.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    full_next     = full_reg;
    wr_sel_next   = wr_sel_reg;
    rd_sel_next   = rd_sel_reg;
    save_ovf_next = save_sop & ~save_ready;
    rd_err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rd_sop) begin
          if (full_reg[rd_sel_reg]) begin
            state_next = STREAM;
            idx_next   = '0;
          end else begin
            rd_err_next = 1'b1;
          end
        end
      end
      STREAM: begin
        if (rd_rdy) begin
          if (idx_reg != LAST_IDX) begin
            idx_next = idx_reg + IDX_W'(1);
          end else begin
            full_next[rd_sel_reg] = 1'b0;
            rd_sel_next           = ~rd_sel_reg;
            state_next            = IDLE;
            idx_next              = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (save_acc) begin
      full_next[wr_sel_reg] = 1'b1;
      wr_sel_next           = ~wr_sel_reg;
    end
  end

  // Read-side outputs follow the state directly so a reset drops them at once.
  always_comb begin
    rd_vld  = (state_reg == STREAM);
    rd_eop  = (state_reg == STREAM) && (idx_reg == LAST_IDX);
    rd_data = '0;
    if (state_reg == STREAM) begin
      if (rd_sel_reg) rd_data = bank1_flat[idx_reg*DATA_W +: DATA_W];
      else            rd_data = bank0_flat[idx_reg*DATA_W +: DATA_W];
    end
  end

  assign save_ovf = save_ovf_reg;
  assign rd_err   = rd_err_reg;
  assign buf_cnt  = {1'b0, full_reg[0]} + {1'b0, full_reg[1]};

endmodule
